scope_capture: RTL

- Upstream stage of the VGA display path: captures 8-bit ADC samples for one oscilloscope sweep and writes them into frame memory.
- Packing: two samples per 16-bit word. Low byte holds the even sample index; high byte holds the odd sample index.
- Word address = sample index >> 1. This matches the byte/word layout the display reader decodes.
- Provides level/slope triggering, an auto-trigger timeout, a post-frame holdoff, and single or continuous run modes.

---
 rtl/scope_capture.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/scope_capture.sv
// Sweep capture: level/slope trigger, auto-timeout and holdoff; packs 8-bit samples in pairs into 16-bit frame-memory words.
// Each word is written one cycle after its odd sample; there is no backpressure, and capture only stalls while sample_valid is low.
module scope_capture #(
    parameter int DEPTH        = 600,
    parameter int ADDR_W       = 16,
    parameter int BASE_ADDR    = 0,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int HOLDOFF      = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              run_mode,
    input  logic              auto_en,
    input  logic              sample_valid,
    input  logic [7:0]        sample,
    input  logic [7:0]        trig_level,
    input  logic              trig_slope,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic [1:0]        state,
    output logic              frame_done,
    output logic              triggered
);

    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam int TO_W  = $clog2(AUTO_TIMEOUT + 1);
    localparam int HO_W  = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        lo_q, lo_d;
    logic [HO_W-1:0]   ho_cnt_q, ho_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              done_q, done_d;
    logic              trig_q, trig_d;

    logic trig_hit;
    logic to_expired;
    logic last_idx;
    logic ho_end;

    // Edge detection needs a valid previous sample, so the first sample after arming never triggers.
    assign trig_hit = prev_vld_q &&
                      (trig_slope ? ((prev_q <  trig_level) && (sample >= trig_level))
                                  : ((prev_q >= trig_level) && (sample <  trig_level)));

    assign to_expired = (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
    assign last_idx   = (idx_q == IDX_W'(DEPTH - 1));
    assign ho_end     = (ho_cnt_q == HO_W'(HOLDOFF - 1));

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        to_cnt_d   = to_cnt_q;
        idx_d      = idx_q;
        lo_d       = lo_q;
        ho_cnt_d   = ho_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        trig_d     = trig_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d    = S_ARMED;
                    prev_vld_d = 1'b0;
                    to_cnt_d   = '0;
                end
            end

            S_ARMED: begin
                if (sample_valid) begin
                    prev_d     = sample;
                    prev_vld_d = 1'b1;
                    if (trig_hit || (auto_en && to_expired)) begin
                        // The starting sample is data index 0 of the new frame.
                        state_d = S_CAPTURE;
                        trig_d  = trig_hit;
                        lo_d    = sample;
                        idx_d   = IDX_W'(1);
                    end else if (!to_expired) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end

            S_CAPTURE: begin
                if (sample_valid) begin
                    if (!idx_q[0]) begin
                        lo_d  = sample;
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        we_d   = 1'b1;
                        data_d = {sample, lo_q};
                        addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q >> 1);
                        if (last_idx) begin
                            done_d   = 1'b1;
                            state_d  = S_HOLDOFF;
                            ho_cnt_d = '0;
                            idx_d    = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end

            S_HOLDOFF: begin
                if (ho_end) begin
                    ho_cnt_d = '0;
                    if (run_mode) begin
                        state_d    = S_ARMED;
                        prev_vld_d = 1'b0;
                        to_cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    ho_cnt_d = ho_cnt_q + HO_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            to_cnt_q   <= '0;
            idx_q      <= '0;
            lo_q       <= '0;
            ho_cnt_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            data_q     <= '0;
            done_q     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            to_cnt_q   <= to_cnt_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            ho_cnt_q   <= ho_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            trig_q     <= trig_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign state      = state_q;
    assign frame_done = done_q;
    assign triggered  = trig_q;

endmodule
